// File: rtl/elevator_floor_ctrl_if.sv
// Call/status bundle between the floor-dispatch controller and its environment.
// The master drives call buttons; the slave (controller) drives the motor command and status.
interface elevator_floor_ctrl_if #(
    parameter int FLOORS = 5
);
    logic [FLOORS-1:0] call_req;
    logic [1:0]        elv1_dir;
    logic [2:0]        cur_floor;
    logic              door_open;
    logic [FLOORS-1:0] call_pending;

    modport master (
        output call_req,
        input  elv1_dir, cur_floor, door_open, call_pending
    );

    modport slave (
        input  call_req,
        output elv1_dir, cur_floor, door_open, call_pending
    );
endinterface

// File: rtl/elevator_floor_ctrl.sv
// SCAN-order floor dispatcher for elevator 1: latches calls, tracks the floor by
// timed travel and drives the 2-bit step-motor direction command.
module elevator_floor_ctrl #(
    parameter int FLOORS      = 5,
    parameter int FLOOR_TICKS = 4800000,
    parameter int DOOR_TICKS  = 2000000
) (
    input  logic                 clk,
    input  logic                 rst,
    elevator_floor_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR      = 2'd3
    } state_t;

    localparam logic [1:0]  DIR_UP     = 2'b00;
    localparam logic [1:0]  DIR_DOWN   = 2'b01;
    localparam logic [1:0]  DIR_STOP   = 2'b10;
    localparam logic [31:0] FLOOR_LAST = 32'(FLOOR_TICKS - 1);
    localparam logic [31:0] DOOR_LAST  = 32'(DOOR_TICKS - 1);
    localparam logic [2:0]  TOP_FLOOR  = 3'(FLOORS - 1);

    state_t            state_r, state_nxt_s;
    logic [2:0]        floor_r, floor_nxt_s;
    logic [31:0]       tcnt_r, tcnt_nxt_s;
    logic [31:0]       dcnt_r, dcnt_nxt_s;
    logic              last_up_r, last_up_nxt_s;
    logic [FLOORS-1:0] pending_r, pending_nxt_s;
    logic [1:0]        dir_r, dir_nxt_s;
    logic              door_r, door_nxt_s;
    logic              above_s, below_s, here_s;
    logic [FLOORS-1:0] arrive_mask_s;

    function automatic logic [FLOORS-1:0] floor_mask(input logic [2:0] f);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++) begin
            m[i] = (int'(f) == i);
        end
        return m;
    endfunction

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [2:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            r = r | (p[i] & (i > int'(f)));
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [2:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            r = r | (p[i] & (i < int'(f)));
        end
        return r;
    endfunction

    // Request summary relative to the current floor, from registered calls only
    always_comb begin
        above_s = any_above(pending_r, floor_r);
        below_s = any_below(pending_r, floor_r);
        here_s  = |(pending_r & floor_mask(floor_r));
    end

    // Next-state, counter, floor and output decode
    always_comb begin
        state_nxt_s   = state_r;
        floor_nxt_s   = floor_r;
        tcnt_nxt_s    = tcnt_r;
        dcnt_nxt_s    = dcnt_r;
        last_up_nxt_s = last_up_r;
        arrive_mask_s = '0;
        case (state_r)
            ST_IDLE: begin
                tcnt_nxt_s = 32'd0;
                dcnt_nxt_s = 32'd0;
                if (here_s) begin
                    state_nxt_s = ST_DOOR;
                end else if (above_s && below_s) begin
                    state_nxt_s = last_up_r ? ST_MOVE_UP : ST_MOVE_DOWN;
                end else if (above_s) begin
                    state_nxt_s = ST_MOVE_UP;
                end else if (below_s) begin
                    state_nxt_s = ST_MOVE_DOWN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MOVE_UP: begin
                if (floor_r >= TOP_FLOOR) begin
                    // Unreachable in normal operation; refuse to run past the top floor
                    state_nxt_s = ST_IDLE;
                    tcnt_nxt_s  = 32'd0;
                end else if (tcnt_r == FLOOR_LAST) begin
                    tcnt_nxt_s    = 32'd0;
                    dcnt_nxt_s    = 32'd0;
                    floor_nxt_s   = floor_r + 3'd1;
                    last_up_nxt_s = 1'b1;
                    arrive_mask_s = floor_mask(floor_r + 3'd1);
                    if (|(pending_r & arrive_mask_s)) begin
                        state_nxt_s = ST_DOOR;
                    end else if (any_above(pending_r, floor_r + 3'd1)) begin
                        state_nxt_s = ST_MOVE_UP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    tcnt_nxt_s = tcnt_r + 32'd1;
                end
            end
            ST_MOVE_DOWN: begin
                if (floor_r == 3'd0) begin
                    state_nxt_s = ST_IDLE;
                    tcnt_nxt_s  = 32'd0;
                end else if (tcnt_r == FLOOR_LAST) begin
                    tcnt_nxt_s    = 32'd0;
                    dcnt_nxt_s    = 32'd0;
                    floor_nxt_s   = floor_r - 3'd1;
                    last_up_nxt_s = 1'b0;
                    arrive_mask_s = floor_mask(floor_r - 3'd1);
                    if (|(pending_r & arrive_mask_s)) begin
                        state_nxt_s = ST_DOOR;
                    end else if (any_below(pending_r, floor_r - 3'd1)) begin
                        state_nxt_s = ST_MOVE_DOWN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    tcnt_nxt_s = tcnt_r + 32'd1;
                end
            end
            ST_DOOR: begin
                tcnt_nxt_s = 32'd0;
                // A fresh press at this floor keeps the door open for a full period
                if (|(bus.call_req & floor_mask(floor_r))) begin
                    dcnt_nxt_s = 32'd0;
                end else if (dcnt_r == DOOR_LAST) begin
                    dcnt_nxt_s = 32'd0;
                    if (last_up_r && above_s) begin
                        state_nxt_s = ST_MOVE_UP;
                    end else if (!last_up_r && below_s) begin
                        state_nxt_s = ST_MOVE_DOWN;
                    end else if (above_s) begin
                        state_nxt_s = ST_MOVE_UP;
                    end else if (below_s) begin
                        state_nxt_s = ST_MOVE_DOWN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    dcnt_nxt_s = dcnt_r + 32'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                tcnt_nxt_s  = 32'd0;
                dcnt_nxt_s  = 32'd0;
            end
        endcase

        // The served floor is whichever floor the car occupies after this edge
        if (state_nxt_s == ST_DOOR) begin
            pending_nxt_s = (pending_r | bus.call_req) & ~floor_mask(floor_nxt_s);
        end else begin
            pending_nxt_s = pending_r | bus.call_req;
        end

        case (state_nxt_s)
            ST_MOVE_UP:   begin dir_nxt_s = DIR_UP;   door_nxt_s = 1'b0; end
            ST_MOVE_DOWN: begin dir_nxt_s = DIR_DOWN; door_nxt_s = 1'b0; end
            ST_DOOR:      begin dir_nxt_s = DIR_STOP; door_nxt_s = 1'b1; end
            default:      begin dir_nxt_s = DIR_STOP; door_nxt_s = 1'b0; end
        endcase
    end

    // State, position, counters, latched calls and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            floor_r   <= 3'd0;
            tcnt_r    <= 32'd0;
            dcnt_r    <= 32'd0;
            last_up_r <= 1'b1;
            pending_r <= '0;
            dir_r     <= DIR_STOP;
            door_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            floor_r   <= floor_nxt_s;
            tcnt_r    <= tcnt_nxt_s;
            dcnt_r    <= dcnt_nxt_s;
            last_up_r <= last_up_nxt_s;
            pending_r <= pending_nxt_s;
            dir_r     <= dir_nxt_s;
            door_r    <= door_nxt_s;
        end
    end

    assign bus.elv1_dir     = dir_r;
    assign bus.cur_floor    = floor_r;
    assign bus.door_open    = door_r;
    assign bus.call_pending = pending_r;

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// Table-driven bench for elevator_floor_ctrl with FLOORS=5, FLOOR_TICKS=10, DOOR_TICKS=5.
module tb_elevator_floor_ctrl;

    localparam int FLOORS = 5;

    typedef struct {
        string      name;
        logic [4:0] call;
        int         ticks;
        logic [1:0] dir;
        logic [2:0] floor;
        logic       door;
        logic [4:0] pend;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl[$];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    elevator_floor_ctrl_if #(.FLOORS(FLOORS)) bus ();

    elevator_floor_ctrl #(
        .FLOORS(FLOORS),
        .FLOOR_TICKS(10),
        .DOOR_TICKS(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic void add(input string n, input logic [4:0] c, input int t,
                                input logic [1:0] d, input logic [2:0] f,
                                input logic o, input logic [4:0] p);
        tbl.push_back('{n, c, t, d, f, o, p});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string n, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            cmp({e.name, ".dir"},   int'(bus.elv1_dir),     int'(e.dir));
            cmp({e.name, ".floor"}, int'(bus.cur_floor),    int'(e.floor));
            cmp({e.name, ".door"},  int'(bus.door_open),    int'(e.door));
            cmp({e.name, ".pend"},  int'(bus.call_pending), int'(e.pend));
        end
    endtask

    // Drive call for the first edge only, advance the remaining edges, then compare
    task automatic apply(input vec_t v);
        sb_q.push_back(v);
        bus.call_req = v.call;
        tick();
        bus.call_req = 5'b00000;
        for (int i = 1; i < v.ticks; i++) tick();
        check_out();
    endtask

    initial begin
        // call at current floor 0
        add("here0",   5'b00001, 1, 2'b10, 3'd0, 1'b0, 5'b00001);
        add("here1",   5'b00000, 1, 2'b10, 3'd0, 1'b1, 5'b00000);
        add("here5",   5'b00000, 4, 2'b10, 3'd0, 1'b1, 5'b00000);
        add("here6",   5'b00000, 1, 2'b10, 3'd0, 1'b0, 5'b00000);
        // single trip 0 -> 2
        add("trip0",   5'b00100, 1, 2'b10, 3'd0, 1'b0, 5'b00100);
        add("trip1",   5'b00000, 1, 2'b00, 3'd0, 1'b0, 5'b00100);
        add("trip10",  5'b00000, 9, 2'b00, 3'd0, 1'b0, 5'b00100);
        add("trip11",  5'b00000, 1, 2'b00, 3'd1, 1'b0, 5'b00100);
        add("trip20",  5'b00000, 9, 2'b00, 3'd1, 1'b0, 5'b00100);
        add("trip21",  5'b00000, 1, 2'b10, 3'd2, 1'b1, 5'b00000);
        add("trip25",  5'b00000, 4, 2'b10, 3'd2, 1'b1, 5'b00000);
        add("trip26",  5'b00000, 1, 2'b10, 3'd2, 1'b0, 5'b00000);
        add("trip31",  5'b00000, 5, 2'b10, 3'd2, 1'b0, 5'b00000);
        // SCAN: at 2 going up, calls 4 and 0
        add("scan0",   5'b10001, 1, 2'b10, 3'd2, 1'b0, 5'b10001);
        add("scan1",   5'b00000, 1, 2'b00, 3'd2, 1'b0, 5'b10001);
        add("scan11",  5'b00000, 10, 2'b00, 3'd3, 1'b0, 5'b10001);
        add("scan21",  5'b00000, 10, 2'b10, 3'd4, 1'b1, 5'b00001);
        add("scan25",  5'b00000, 4, 2'b10, 3'd4, 1'b1, 5'b00001);
        add("scan26",  5'b00000, 1, 2'b01, 3'd4, 1'b0, 5'b00001);
        add("scan36",  5'b00000, 10, 2'b01, 3'd3, 1'b0, 5'b00001);
        add("scan65",  5'b00000, 29, 2'b01, 3'd1, 1'b0, 5'b00001);
        add("scan66",  5'b00000, 1, 2'b10, 3'd0, 1'b1, 5'b00000);
        add("scan70",  5'b00000, 4, 2'b10, 3'd0, 1'b1, 5'b00000);
        add("scan71",  5'b00000, 1, 2'b10, 3'd0, 1'b0, 5'b00000);
        // pick-up en route 0 -> 4 with stop at 3
        add("pick0",   5'b10000, 1, 2'b10, 3'd0, 1'b0, 5'b10000);
        add("pick1",   5'b00000, 1, 2'b00, 3'd0, 1'b0, 5'b10000);
        add("pick11",  5'b00000, 10, 2'b00, 3'd1, 1'b0, 5'b10000);
        add("pick12",  5'b01000, 1, 2'b00, 3'd1, 1'b0, 5'b11000);
        add("pick21",  5'b00000, 9, 2'b00, 3'd2, 1'b0, 5'b11000);
        add("pick31",  5'b00000, 10, 2'b10, 3'd3, 1'b1, 5'b10000);
        add("pick36",  5'b00000, 5, 2'b00, 3'd3, 1'b0, 5'b10000);
        add("pick46",  5'b00000, 10, 2'b10, 3'd4, 1'b1, 5'b00000);
        add("pick51",  5'b00000, 5, 2'b10, 3'd4, 1'b0, 5'b00000);
        // back down 4 -> 0 in one run
        add("down0",   5'b00001, 1, 2'b10, 3'd4, 1'b0, 5'b00001);
        add("down1",   5'b00000, 1, 2'b01, 3'd4, 1'b0, 5'b00001);
        add("down41",  5'b00000, 40, 2'b10, 3'd0, 1'b1, 5'b00000);
        add("down46",  5'b00000, 5, 2'b10, 3'd0, 1'b0, 5'b00000);
        // re-press at the open floor restarts the door timer
        add("rst_dr0", 5'b00001, 1, 2'b10, 3'd0, 1'b0, 5'b00001);
        add("rst_dr3", 5'b00000, 3, 2'b10, 3'd0, 1'b1, 5'b00000);
        add("rst_dr4", 5'b00001, 1, 2'b10, 3'd0, 1'b1, 5'b00000);
        add("rst_dr8", 5'b00000, 4, 2'b10, 3'd0, 1'b1, 5'b00000);
        add("rst_dr9", 5'b00000, 1, 2'b10, 3'd0, 1'b0, 5'b00000);

        bus.call_req = 5'b00000;
        rst = 1'b1;
        apply('{"reset1", 5'b00000, 1, 2'b10, 3'd0, 1'b0, 5'b00000});
        apply('{"reset3", 5'b00000, 2, 2'b10, 3'd0, 1'b0, 5'b00000});
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // reset in the middle of a move, then no motion without new calls
        apply('{"mm0",      5'b00100, 1, 2'b10, 3'd0, 1'b0, 5'b00100});
        apply('{"mm1",      5'b00000, 1, 2'b00, 3'd0, 1'b0, 5'b00100});
        apply('{"mm13",     5'b00000, 12, 2'b00, 3'd1, 1'b0, 5'b00100});
        rst = 1'b1;
        apply('{"mm_rst",   5'b00000, 1, 2'b10, 3'd0, 1'b0, 5'b00000});
        rst = 1'b0;
        apply('{"mm_quiet", 5'b00000, 30, 2'b10, 3'd0, 1'b0, 5'b00000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/elevator_floor_ctrl.md
Name: elevator_floor_ctrl

Overview:
Floor-dispatch controller for elevator 1. It sits directly upstream of the step-motor driver and produces the 2-bit direction command elv1_dir that the driver consumes. It latches floor call buttons and tracks the current floor by timing travel. It serves calls in SCAN (collective) order and holds the car stopped with the door open at each served floor.

Parameters:
FLOORS, 5, number of floors; legal range 2..8; floors are numbered 0..FLOORS-1.
FLOOR_TICKS, 4800000, clk cycles of motor travel per floor (5 full motor phase cycles of 960000).
DOOR_TICKS, 2000000, clk cycles the door stays open at a served floor.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
call_req  in  FLOORS  floor call buttons; bit i=1 requests floor i; may be a pulse or a level
elv1_dir  out  2  direction command to motor driver: 2'b00 up, 2'b01 down, 2'b10 stop (2'b11 never driven)
cur_floor  out  3  current floor index, registered
door_open  out  1  1 while the door is open at cur_floor
call_pending  out  FLOORS  latched, unserved calls

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst), and has priority over everything, including mid-travel.
- Reset values:
  - state=IDLE, elv1_dir=2'b10, cur_floor=0, door_open=0, call_pending=0, last_dir=UP.
  - Travel and door counters = 0.
- Call latching:
  - Every edge: call_pending <= call_pending | call_req, except that the bit for cur_floor is cleared on any edge where the state enters or remains in DOOR.
  - FSM decisions use the registered call_pending only. A call sampled at edge N first influences the FSM at edge N+1.
- Definitions: above = any pending bit > cur_floor; below = any pending bit < cur_floor; here = pending[cur_floor].
- States:
  - IDLE: elv1_dir=2'b10, door_open=0.
    - If here, go to DOOR.
    - Else if above and below are both set, move in last_dir.
    - Else if above, go to MOVE_UP; else if below, go to MOVE_DOWN.
    - Otherwise stay in IDLE.
  - MOVE_UP / MOVE_DOWN: elv1_dir=2'b00 / 2'b01, door_open=0.
    - The travel counter counts 0..FLOOR_TICKS-1.
    - At FLOOR_TICKS-1: cur_floor increments or decrements by 1 and the counter returns to 0; last_dir is set to the move direction.
    - Arrival decision, using pending at the new floor:
      - If that bit is set, go to DOOR.
      - Else, if further requests exist in the same direction, stay in the move state.
      - Else go to IDLE.
    - cur_floor never leaves 0..FLOORS-1. A move state is entered only when a request exists beyond cur_floor in that direction.
  - DOOR: elv1_dir=2'b10, door_open=1.
    - The door counter counts 0..DOOR_TICKS-1.
    - A new call_req for cur_floor while in DOOR restarts the counter at 0 and is not latched.
    - At DOOR_TICKS-1:
      - If there is a request in last_dir, move in last_dir.
      - Else if there is a request in the opposite direction, move in that direction.
      - Else go to IDLE.
- Outputs are registered and change on the same edge as the state; there is no combinational path from call_req to any output.
- Latency: a call sampled at edge N while in IDLE produces elv1_dir/door_open changes after edge N+1.
- A move of k floors holds elv1_dir constant for k*FLOOR_TICKS cycles when no intermediate stops occur.
- A call for a floor the car is just departing, or for the floor the car arrives at on that same edge, stays pending and is served on a later pass.
- Counters are 32 bits wide. Parameters must fit in 32 bits; no wrap-around is possible.

Test Plan (FLOORS=5, FLOOR_TICKS=10, DOOR_TICKS=5):
1. Reset: assert rst 3 cycles -> elv1_dir=2'b10, cur_floor=0, door_open=0, call_pending=0 on the first edge with rst high.
2. Single trip: idle at 0, 1-cycle pulse on call_req[2] -> call_pending=5'b00100 next edge; elv1_dir=2'b00 one edge later for 20 cycles; cur_floor=1 after 10 cycles, 2 after 20; door_open=1 for 5 cycles with call_pending=0; then elv1_dir=2'b10 idle.
3. Call at current floor: idle at 0, call_req[0] -> door_open=1 for 5 cycles, elv1_dir stays 2'b10, cur_floor stays 0.
4. SCAN order: car at 2 with last_dir=UP, simultaneous calls on floors 4 and 0 -> up to 4 (20 cycles), door 5 cycles, then elv1_dir=2'b01 for 40 cycles down to 0, door, idle.
5. Pick-up en route: moving 0->4, call_req[3] pulsed while cur_floor=1 -> stops at 3 with door_open, then continues to 4.
6. Reset mid-move: rst high during MOVE_UP at cur_floor=1 -> next edge elv1_dir=2'b10, cur_floor=0, call_pending=0; no motion after rst is released without new calls.
